// File: rtl/jtag_master_p2b_converter.sv
`default_nettype none
// ============================================================================
// Module   : jtag_master_p2b_converter
// Purpose  : Packets-to-bytes converter for the JTAG master bridge response
//            path. Turns an Avalon-ST packet stream (with channel) into a
//            flat byte stream carrying in-band framing characters:
//              0x7A SOP, 0x7B EOP, 0x7C channel, 0x7D escape.
//            Bytes 0x7A..0x7D in channel or data positions are sent as
//            0x7D followed by (byte ^ 0x20).
// Ports    : clk, reset (async, active-high)
//            in_ready/in_valid/in_data/in_startofpacket/in_endofpacket/
//            in_channel : packet-side sink
//            out_ready/out_valid/out_data : byte-side source (registered)
// Config   : P2B_CHANNEL_EN - when defined, channel markers are emitted on
//            SOP beats whose channel differs from the last one sent.
//            When undefined, in_channel is ignored entirely.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_master_p2b_converter (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic [7:0] in_channel,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data
);

  localparam logic [7:0] C_SOP_CHAR = 8'h7A;
  localparam logic [7:0] C_EOP_CHAR = 8'h7B;
  localparam logic [7:0] C_CH_CHAR  = 8'h7C;
  localparam logic [7:0] C_ESC_CHAR = 8'h7D;
  localparam logic [7:0] C_ESC_XOR  = 8'h20;

  // State names the byte that will be loaded into the output register next.
  // The encoding order matches the emission order so steps can be skipped
  // by magnitude comparison.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CH_MARK  = 4'd1,
    CH_ESC   = 4'd2,
    CH_BYTE  = 4'd3,
    SOP_MARK = 4'd4,
    EOP_MARK = 4'd5,
    D_ESC    = 4'd6,
    DATA     = 4'd7
  } state_t;

  function automatic logic needs_esc(input logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

  // First step at or after 'from' whose condition holds; DATA always holds.
  function automatic state_t step_from(
    input state_t from,
    input logic   need_ch,
    input logic   ch_esc,
    input logic   sop,
    input logic   eop,
    input logic   d_esc
  );
    state_t s;
    s = DATA;
    if ((from <= D_ESC)    && d_esc)             s = D_ESC;
    if ((from <= EOP_MARK) && eop)               s = EOP_MARK;
    if ((from <= SOP_MARK) && sop)               s = SOP_MARK;
    if ((from <= CH_BYTE)  && need_ch)           s = CH_BYTE;
    if ((from <= CH_ESC)   && need_ch && ch_esc) s = CH_ESC;
    if ((from <= CH_MARK)  && need_ch)           s = CH_MARK;
    return s;
  endfunction

  function automatic state_t succ(input state_t s);
    state_t n;
    case (s)
      IDLE:     n = CH_MARK;
      CH_MARK:  n = CH_ESC;
      CH_ESC:   n = CH_BYTE;
      CH_BYTE:  n = SOP_MARK;
      SOP_MARK: n = EOP_MARK;
      EOP_MARK: n = D_ESC;
      default:  n = DATA;
    endcase
    return n;
  endfunction

  // Holding register
  logic       r_held;
  logic [7:0] r_data;
  logic       r_sop;
  logic       r_eop;
  state_t     r_state;

  logic       w_load;
  logic       w_accept;
  logic       w_have;
  logic [7:0] w_cur_data;
  logic       w_cur_sop;
  logic       w_cur_eop;
  logic [7:0] w_cur_chan;
  logic       w_need_ch;
  logic       w_ch_esc;
  logic       w_in_need_ch;
  state_t     w_in_first;
  state_t     w_cur_state;
  state_t     w_next;
  logic [7:0] w_byte;

  assign w_load   = !out_valid || out_ready;
  // Combinational from out_ready so a new beat can be taken on the same edge
  // that the final DATA byte of the held beat is loaded.
  assign in_ready = !reset && (!r_held || ((r_state == DATA) && w_load));
  assign w_accept = in_valid && in_ready;

  // With nothing held, an accepted beat is encoded straight from the inputs
  // so its first byte appears the cycle after acceptance.
  assign w_have     = r_held || w_accept;
  assign w_cur_data = r_held ? r_data : in_data;
  assign w_cur_sop  = r_held ? r_sop  : in_startofpacket;
  assign w_cur_eop  = r_held ? r_eop  : in_endofpacket;

`ifdef P2B_CHANNEL_EN
  logic [7:0] r_chan;
  logic [7:0] r_last_channel;
  logic       r_chan_known;

  assign w_cur_chan   = r_held ? r_chan : in_channel;
  assign w_need_ch    = w_cur_sop && (!r_chan_known || (w_cur_chan != r_last_channel));
  assign w_ch_esc     = needs_esc(w_cur_chan);
  assign w_in_need_ch = in_startofpacket &&
                        (!r_chan_known || (in_channel != r_last_channel));
  assign w_in_first   = step_from(CH_MARK, w_in_need_ch, needs_esc(in_channel),
                                  in_startofpacket, in_endofpacket, needs_esc(in_data));
`else
  logic w_unused_channel;

  assign w_unused_channel = ^in_channel;
  assign w_cur_chan       = 8'h00;
  assign w_need_ch        = 1'b0;
  assign w_ch_esc         = 1'b0;
  assign w_in_need_ch     = 1'b0;
  assign w_in_first       = step_from(CH_MARK, 1'b0, 1'b0, in_startofpacket,
                                      in_endofpacket, needs_esc(in_data));
`endif

  assign w_cur_state = r_held ? r_state : w_in_first;
  assign w_next      = step_from(succ(w_cur_state), w_need_ch, w_ch_esc,
                                 w_cur_sop, w_cur_eop, needs_esc(w_cur_data));

  always_comb begin
    w_byte = 8'h00;
    case (w_cur_state)
      CH_MARK:  w_byte = C_CH_CHAR;
      CH_ESC:   w_byte = C_ESC_CHAR;
      CH_BYTE:  w_byte = w_ch_esc ? (w_cur_chan ^ C_ESC_XOR) : w_cur_chan;
      SOP_MARK: w_byte = C_SOP_CHAR;
      EOP_MARK: w_byte = C_EOP_CHAR;
      D_ESC:    w_byte = C_ESC_CHAR;
      DATA:     w_byte = needs_esc(w_cur_data) ? (w_cur_data ^ C_ESC_XOR) : w_cur_data;
      default:  w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held    <= 1'b0;
      r_data    <= 8'h00;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_state   <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
`ifdef P2B_CHANNEL_EN
      r_chan         <= 8'h00;
      r_last_channel <= 8'h00;
      r_chan_known   <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        out_valid <= w_have;
        if (w_have) begin
          out_data <= w_byte;
`ifdef P2B_CHANNEL_EN
          if (w_cur_state == CH_BYTE) begin
            r_last_channel <= w_cur_chan;
            r_chan_known   <= 1'b1;
          end
`endif
          if (w_cur_state == DATA) begin
            if (r_held && w_accept) begin
              // Held beat finishes; the next beat is captured on this edge.
              r_held  <= 1'b1;
              r_data  <= in_data;
              r_sop   <= in_startofpacket;
              r_eop   <= in_endofpacket;
              r_state <= w_in_first;
`ifdef P2B_CHANNEL_EN
              r_chan  <= in_channel;
`endif
            end else begin
              r_held  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_held  <= 1'b1;
            r_state <= w_next;
            if (!r_held) begin
              r_data <= in_data;
              r_sop  <= in_startofpacket;
              r_eop  <= in_endofpacket;
`ifdef P2B_CHANNEL_EN
              r_chan <= in_channel;
`endif
            end
          end
        end
      end else if (w_accept) begin
        // Output stalled with nothing held: park the beat for later.
        r_held  <= 1'b1;
        r_data  <= in_data;
        r_sop   <= in_startofpacket;
        r_eop   <= in_endofpacket;
        r_state <= w_in_first;
`ifdef P2B_CHANNEL_EN
        r_chan  <= in_channel;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master_p2b_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_master_p2b_converter
// Purpose  : Self-checking bench for jtag_master_p2b_converter. Expected
//            bytes are queued when beats are driven and compared as the DUT
//            hands bytes downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_master_p2b_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic [7:0] in_channel;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       m_known;
  logic [7:0] m_last;

  logic rand_ready;
  logic fixed_ready;
  logic chk_gap;
  int   ncyc;
  int   last_pop;
  logic prev_stall;
  logic [7:0] prev_data;

  jtag_master_p2b_converter dut (
    .clk              (clk),
    .reset            (reset),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .in_channel       (in_channel),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Scoreboard monitor: sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    ncyc++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%02h, need valid=1 data=%02h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, need no byte", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_byte: got %02h, need %02h", out_data, e);
          end
          if (chk_gap && last_pop >= 0) begin
            checks++;
            if (ncyc - last_pop != 1) begin
              errors++;
              $display("FAIL byte_gap: got %0d cycles between bytes, need 1", ncyc - last_pop);
            end
          end
          last_pop = ncyc;
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
    end
  end

  task automatic push_esc(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  // Reference encoder; with push=0 it only tracks the channel state.
  task automatic model_beat(input logic [7:0] d, input logic sop, input logic eop,
                            input logic [7:0] ch, input logic push);
`ifdef P2B_CHANNEL_EN
    if (sop && (!m_known || ch != m_last)) begin
      if (push) begin
        exp_q.push_back(8'h7C);
        push_esc(ch);
      end
      m_known = 1'b1;
      m_last  = ch;
    end
`endif
    if (push) begin
      if (sop) exp_q.push_back(8'h7A);
      if (eop) exp_q.push_back(8'h7B);
      push_esc(d);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop,
                           input logic [7:0] ch);
    bit ok;
    ok = 1'b0;
    in_valid         = 1'b1;
    in_data          = d;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_channel       = ch;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=%b after 500 cycles, need 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d bytes outstanding, need 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b, need 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_data: got %02h, need 00", out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, need 0", in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_known = 1'b0;
    m_last  = 8'h00;
    exp_q.delete();
  endtask

  task automatic test_single;
    fixed_ready = 1'b1;
    @(posedge clk);
    #2;
    chk_gap  = 1'b1;
    last_pop = -1;
`ifdef P2B_CHANNEL_EN
    exp_q.push_back(8'h7C);
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'h41);
    model_beat(8'h41, 1'b1, 1'b1, 8'h00, 1'b0);
    send_beat(8'h41, 1'b1, 1'b1, 8'h00);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_latency: got out_valid=%b one cycle after accept, need 1", out_valid);
    end
    wait_drain(50);
  endtask

  task automatic test_escape_packet;
    last_pop = -1;
`ifdef P2B_CHANNEL_EN
    exp_q.push_back(8'h7C);
    exp_q.push_back(8'h02);
`endif
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h7D);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'h20);
    model_beat(8'h10, 1'b1, 1'b0, 8'h02, 1'b0);
    send_beat(8'h10, 1'b1, 1'b0, 8'h02);
    send_beat(8'h7A, 1'b0, 1'b0, 8'hEE);
    send_beat(8'h20, 1'b0, 1'b1, 8'hEE);
    wait_drain(50);
  endtask

  task automatic test_back_to_back;
    last_pop = -1;
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'h33);
`ifdef P2B_CHANNEL_EN
    exp_q.push_back(8'h7C);
    exp_q.push_back(8'h7D);
    exp_q.push_back(8'h5D);
`endif
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'h44);
    model_beat(8'h33, 1'b1, 1'b1, 8'h02, 1'b0);
    model_beat(8'h44, 1'b1, 1'b1, 8'h7D, 1'b0);
    send_beat(8'h33, 1'b1, 1'b1, 8'h02);
    send_beat(8'h44, 1'b1, 1'b1, 8'h7D);
    wait_drain(50);
  endtask

  task automatic test_random;
    logic [7:0] chans[6];
    logic [7:0] ch;
    logic [7:0] d;
    int len;
    chans[0] = 8'h00; chans[1] = 8'h02; chans[2] = 8'h7A;
    chans[3] = 8'h7B; chans[4] = 8'h7C; chans[5] = 8'h7D;
    chk_gap    = 1'b0;
    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      ch  = chans[$urandom_range(0, 5)];
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) d = 8'(8'h7A + $urandom_range(0, 3));
        else d = 8'($urandom_range(0, 255));
        model_beat(d, b == 0, b == len - 1, ch, 1'b1);
        send_beat(d, b == 0, b == len - 1, (b == 0) ? ch : 8'($urandom_range(0, 255)));
      end
    end
    wait_drain(2000);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset_mid_escape;
    fixed_ready = 1'b0;
    @(posedge clk);
    #2;
    send_beat(8'h7A, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h7D) begin
      errors++;
      $display("FAIL escape_stall: got valid=%b data=%02h, need valid=1 data=7D",
               out_valid, out_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: got out_valid=%b, need 0", out_valid);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    m_known     = 1'b0;
    m_last      = 8'h00;
    fixed_ready = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2;
    chk_gap  = 1'b1;
    last_pop = -1;
`ifdef P2B_CHANNEL_EN
    exp_q.push_back(8'h7C);
    exp_q.push_back(8'h05);
`endif
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'h01);
    model_beat(8'h01, 1'b1, 1'b1, 8'h05, 1'b0);
    send_beat(8'h01, 1'b1, 1'b1, 8'h05);
    wait_drain(50);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, need completion");
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = 8'h00;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_channel       = 8'h00;
    out_ready        = 1'b0;
    rand_ready       = 1'b0;
    fixed_ready      = 1'b0;
    chk_gap          = 1'b0;
    ncyc             = 0;
    last_pop         = -1;
    prev_stall       = 1'b0;
    prev_data        = 8'h00;
    m_known          = 1'b0;
    m_last           = 8'h00;

    test_reset();
    test_single();
    test_escape_packet();
    test_back_to_back();
    test_random();
    test_reset_mid_escape();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
